bms_fault_detector: RTL and testbench
=====================================

Name: bms_fault_detector

Overview:
- Upstream stage of the pack protection state machine.
- Converts raw measurements into debounced, hysteretic fault flags: ov_fault, uv_fault, oc_fault and ot_fault.
- Measurements are max/min cell voltage, pack current and temperature, qualified by a sample strobe from the ADC/AFE interface.
- Flags are registered and drive the protection FSM fault inputs directly.

Parameters:
- OV_SET_MV, 4200, overvoltage assert threshold on max_cell_mv (mV).
- OV_CLR_MV, 4150, overvoltage release threshold (mV); must be < OV_SET_MV.
- UV_SET_MV, 3000, undervoltage assert threshold on min_cell_mv (mV).
- UV_CLR_MV, 3100, undervoltage release threshold (mV); must be > UV_SET_MV.
- OC_SET_MA, 20000, overcurrent assert threshold on |current_ma|.
- OC_CLR_MA, 18000, overcurrent release threshold on |current_ma|.
- OT_SET_C, 60, overtemperature assert threshold (degC, signed).
- OT_CLR_C, 55, overtemperature release threshold (degC, signed).
- DEB_CNT, 4, consecutive qualifying samples needed to assert or release (1..15).
- CNT_W, 4, debounce counter width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_valid  input  1  one-cycle strobe; measurement inputs are valid this cycle
- max_cell_mv  input  16  highest cell voltage, unsigned mV
- min_cell_mv  input  16  lowest cell voltage, unsigned mV
- current_ma  input  16  signed pack current, mA (+ discharge, − charge)
- temp_c  input  8  signed hottest-sensor temperature, degC
- clear_faults  input  1  one-cycle latch clear request (used only with the option)
- ov_fault  output  1  debounced overvoltage
- uv_fault  output  1  debounced undervoltage
- oc_fault  output  1  debounced overcurrent
- ot_fault  output  1  debounced overtemperature
- fault_any  output  1  registered OR of the four flags

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. Reset clears all flags and counters to 0, places every channel in CLEAR and drives fault_any to 0.
- Four identical, independent channels. Each channel has a 2-state FSM (CLEAR, ASSERTED) and a CNT_W-bit counter.
- Comparisons (inclusive):
  - OV: set when max_cell_mv >= OV_SET_MV; clear when max_cell_mv <= OV_CLR_MV.
  - UV: set when min_cell_mv <= UV_SET_MV; clear when min_cell_mv >= UV_CLR_MV.
  - OC: set when abs >= OC_SET_MA; clear when abs <= OC_CLR_MA. abs is the 16-bit magnitude of current_ma; −32768 saturates to 32767.
  - OT: set when temp_c >= OT_SET_C; clear when temp_c <= OT_CLR_C. Signed compare.
- Debounce counting happens only on cycles with sample_valid=1. Without sample_valid, state and counter hold.
- CLEAR state:
  - Valid sample meeting set condition: counter increments.
  - Any other valid sample, including one inside the hysteresis band: counter resets to 0.
  - When the DEB_CNT-th consecutive set sample arrives, the channel moves to ASSERTED, the flag goes to 1 and the counter resets to 0.
- ASSERTED state: mirror of CLEAR using the clear condition. On the DEB_CNT-th consecutive clear sample, the channel returns to CLEAR and the flag goes to 0.
- Latency: the flag changes on the clk edge that samples the DEB_CNT-th qualifying strobe, i.e. registered, one cycle after that strobe is presented.
- fault_any is registered from the next-state flags, so it changes on the same edge as the flags.
- DEB_CNT=1: a single qualifying sample toggles the flag.
- The counter never exceeds DEB_CNT-1; no wrap-around.
- Channels are independent: OV and UV may both be 1 simultaneously (sensor disagreement). No arbitration in this block.
- Reset asserted mid-debounce discards partial counts immediately.

Optional Feature:
- Macro: BMS_FAULT_LATCH_EN.
- Defined:
  - OV, OC and OT become latching. The ASSERTED to CLEAR transition needs the release debounce to complete AND a clear_faults pulse.
  - clear_faults takes effect only if the channel's release counter has already reached DEB_CNT consecutive clear samples. A pulse arriving earlier is ignored and not remembered.
  - UV stays non-latching.
- Undefined: all channels self-release via hysteresis, and clear_faults is ignored.

Test Plan:
- OV assert: reset, then 4 strobes with max_cell_mv=4200 -> ov_fault=0 after strobes 1–3, =1 on the edge of strobe 4; fault_any=1.
- OV hysteresis: from ov_fault=1, strobes of 4180 (band) ×10 -> flag stays 1. Then 3×4150, 1×4180, 4×4150 -> flag releases only on the 4th strobe of the final run.
- Debounce reset: 3×4200, 1×4199, 3×4200 -> ov_fault stays 0. One further 4200 strobe -> ov_fault=1.
- OC magnitude: 4 strobes of current_ma=−20000 -> oc_fault=1. Restart, 4 strobes of −32768 -> oc_fault=1 (saturated abs). 4 strobes of 19000 -> no change (band).
- OT signed and UV: temp_c=−40 ×4 -> ot_fault=0. temp_c=60 ×4 -> ot_fault=1. min_cell_mv=3000 ×4 -> uv_fault=1 concurrently; fault_any=1.
- Reset mid-operation and latch option: assert rst_n=0 during the 3rd qualifying strobe -> all flags 0 and counting restarts. With BMS_FAULT_LATCH_EN: ot_fault set, 4×temp_c=50 -> stays 1 until a clear_faults pulse -> 0 next edge. A clear_faults pulse before release completes -> no effect.

Source files
------------

// File: rtl/bms_fault_detector.sv
// Debounced, hysteretic OV/UV/OC/OT fault flags for the pack protection FSM.
// Build option BMS_FAULT_LATCH_EN makes OV/OC/OT latching until clear_faults.
module bms_fault_detector #(
    parameter int unsigned OV_SET_MV = 4200,
    parameter int unsigned OV_CLR_MV = 4150,
    parameter int unsigned UV_SET_MV = 3000,
    parameter int unsigned UV_CLR_MV = 3100,
    parameter int unsigned OC_SET_MA = 20000,
    parameter int unsigned OC_CLR_MA = 18000,
    parameter int          OT_SET_C  = 60,
    parameter int          OT_CLR_C  = 55,
    parameter int unsigned DEB_CNT   = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [15:0] max_cell_mv,
    input  logic [15:0] min_cell_mv,
    input  logic [15:0] current_ma,
    input  logic [7:0]  temp_c,
    input  logic        clear_faults,
    output logic        ov_fault,
    output logic        uv_fault,
    output logic        oc_fault,
    output logic        ot_fault,
    output logic        fault_any
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned CH_OV = 0;
    localparam int unsigned CH_UV = 1;
    localparam int unsigned CH_OC = 2;
    localparam int unsigned CH_OT = 3;

    localparam logic [15:0]        OV_SET = 16'(OV_SET_MV);
    localparam logic [15:0]        OV_CLR = 16'(OV_CLR_MV);
    localparam logic [15:0]        UV_SET = 16'(UV_SET_MV);
    localparam logic [15:0]        UV_CLR = 16'(UV_CLR_MV);
    localparam logic [15:0]        OC_SET = 16'(OC_SET_MA);
    localparam logic [15:0]        OC_CLR = 16'(OC_CLR_MA);
    localparam logic signed [7:0]  OT_SET = 8'(OT_SET_C);
    localparam logic signed [7:0]  OT_CLR = 8'(OT_CLR_C);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CNT - 1);

`ifdef BMS_FAULT_LATCH_EN
    localparam logic [NCH-1:0] LATCH_MASK = 4'b1101;
`else
    localparam logic [NCH-1:0] LATCH_MASK = 4'b0000;
`endif

    typedef enum logic {
        ST_CLEAR    = 1'b0,
        ST_ASSERTED = 1'b1
    } state_e;

    state_e             state_q [NCH];
    state_e             state_d [NCH];
    logic [CNT_W-1:0]   cnt_q   [NCH];
    logic [CNT_W-1:0]   cnt_d   [NCH];
    logic [NCH-1:0]     rel_done_q, rel_done_d;
    logic [NCH-1:0]     flags_d;
    logic               fault_any_q;
    logic [NCH-1:0]     set_cond, clr_cond;
    logic [15:0]        cur_abs;

    // Threshold comparisons; -32768 saturates to 32767 in the magnitude.
    always_comb begin
        cur_abs = current_ma;
        if (current_ma[15]) begin
            cur_abs = (current_ma == 16'h8000) ? 16'h7FFF : 16'(~current_ma + 16'd1);
        end
        set_cond = '0;
        clr_cond = '0;
        set_cond[CH_OV] = (max_cell_mv >= OV_SET);
        clr_cond[CH_OV] = (max_cell_mv <= OV_CLR);
        set_cond[CH_UV] = (min_cell_mv <= UV_SET);
        clr_cond[CH_UV] = (min_cell_mv >= UV_CLR);
        set_cond[CH_OC] = (cur_abs >= OC_SET);
        clr_cond[CH_OC] = (cur_abs <= OC_CLR);
        set_cond[CH_OT] = ($signed(temp_c) >= OT_SET);
        clr_cond[CH_OT] = ($signed(temp_c) <= OT_CLR);
    end

    // Per-channel debounce FSM; rel_done marks a completed release awaiting clear_faults.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            rel_done_d[i] = rel_done_q[i];
            flags_d[i]    = 1'b0;
            case (state_q[i])
                ST_CLEAR: begin
                    if (sample_valid) begin
                        if (set_cond[i]) begin
                            if (cnt_q[i] == CNT_LAST) begin
                                state_d[i] = ST_ASSERTED;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                            end
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
                end
                ST_ASSERTED: begin
                    if (LATCH_MASK[i] && rel_done_q[i]) begin
                        if (clear_faults) begin
                            state_d[i]    = ST_CLEAR;
                            rel_done_d[i] = 1'b0;
                            cnt_d[i]      = '0;
                        end else if (sample_valid && !clr_cond[i]) begin
                            rel_done_d[i] = 1'b0;
                        end
                    end else if (sample_valid) begin
                        if (clr_cond[i]) begin
                            if (cnt_q[i] == CNT_LAST) begin
                                cnt_d[i] = '0;
                                if (LATCH_MASK[i]) begin
                                    rel_done_d[i] = 1'b1;
                                end else begin
                                    state_d[i] = ST_CLEAR;
                                end
                            end else begin
                                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                            end
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_CLEAR;
                    cnt_d[i]   = '0;
                end
            endcase
            flags_d[i] = (state_d[i] == ST_ASSERTED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_CLEAR;
                cnt_q[i]   <= '0;
            end
            rel_done_q  <= '0;
            fault_any_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            rel_done_q  <= rel_done_d;
            fault_any_q <= |flags_d;
        end
    end

    assign ov_fault  = (state_q[CH_OV] == ST_ASSERTED);
    assign uv_fault  = (state_q[CH_UV] == ST_ASSERTED);
    assign oc_fault  = (state_q[CH_OC] == ST_ASSERTED);
    assign ot_fault  = (state_q[CH_OT] == ST_ASSERTED);
    assign fault_any = fault_any_q;

endmodule

// File: tb/tb_bms_fault_detector.sv
// Bench for bms_fault_detector: directed scenarios plus randomized strobes vs. a behavioural model.
module tb_bms_fault_detector;

    localparam int DEB = 4;
    localparam logic [15:0] NMX  = 16'd3700;
    localparam logic [15:0] NMN  = 16'd3700;
    localparam logic [15:0] NCUR = 16'd0;
    localparam logic [7:0]  NT   = 8'd25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] max_cell_mv, min_cell_mv, current_ma;
    logic [7:0]  temp_c;
    logic        clear_faults;
    logic        ov_fault, uv_fault, oc_fault, ot_fault, fault_any;

    int n_checks = 0;
    int n_errors = 0;

    bit m_asrt  [4];
    int m_cnt   [4];
    bit m_rdy   [4];
    bit m_latch [4];

    always #5 clk = ~clk;

    bms_fault_detector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .max_cell_mv  (max_cell_mv),
        .min_cell_mv  (min_cell_mv),
        .current_ma   (current_ma),
        .temp_c       (temp_c),
        .clear_faults (clear_faults),
        .ov_fault     (ov_fault),
        .uv_fault     (uv_fault),
        .oc_fault     (oc_fault),
        .ot_fault     (ot_fault),
        .fault_any    (fault_any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Threshold rules evaluated on plain integers.
    function automatic bit meets(input int ch, input bit for_set, input logic [15:0] mx,
                                 input logic [15:0] mn, input logic [15:0] cur, input logic [7:0] t);
        int vmx, vmn, a, tc;
        vmx = int'(mx);
        vmn = int'(mn);
        a   = int'($signed(cur));
        tc  = int'($signed(t));
        if (a < 0) a = -a;
        if (a > 32767) a = 32767;
        case (ch)
            0:       return for_set ? (vmx >= 4200) : (vmx <= 4150);
            1:       return for_set ? (vmn <= 3000) : (vmn >= 3100);
            2:       return for_set ? (a >= 20000) : (a <= 18000);
            default: return for_set ? (tc >= 60) : (tc <= 55);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_asrt[i] = 0;
            m_cnt[i]  = 0;
            m_rdy[i]  = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic [15:0] mx, input logic [15:0] mn,
                              input logic [15:0] cur, input logic [7:0] t, input logic clr);
        bit q;
        for (int ch = 0; ch < 4; ch++) begin
            if (clr && m_latch[ch] && m_asrt[ch] && m_rdy[ch]) begin
                m_asrt[ch] = 0;
                m_rdy[ch]  = 0;
                m_cnt[ch]  = 0;
            end else if (v) begin
                q = meets(ch, !m_asrt[ch], mx, mn, cur, t);
                if (m_asrt[ch] && m_rdy[ch]) begin
                    if (!q) m_rdy[ch] = 0;
                end else if (q) begin
                    m_cnt[ch]++;
                    if (m_cnt[ch] == DEB) begin
                        m_cnt[ch] = 0;
                        if (m_asrt[ch] && m_latch[ch]) m_rdy[ch] = 1;
                        else m_asrt[ch] = !m_asrt[ch];
                    end
                end else begin
                    m_cnt[ch] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        check("ov", 32'(ov_fault), 32'(m_asrt[0]));
        check("uv", 32'(uv_fault), 32'(m_asrt[1]));
        check("oc", 32'(oc_fault), 32'(m_asrt[2]));
        check("ot", 32'(ot_fault), 32'(m_asrt[3]));
        check("any", 32'(fault_any), 32'(m_asrt[0] | m_asrt[1] | m_asrt[2] | m_asrt[3]));
    endtask

    task automatic cyc(input logic v, input logic [15:0] mx, input logic [15:0] mn,
                       input logic [15:0] cur, input logic [7:0] t, input logic clr);
        @(negedge clk);
        sample_valid = v;
        max_cell_mv  = mx;
        min_cell_mv  = mn;
        current_ma   = cur;
        temp_c       = t;
        clear_faults = clr;
        @(posedge clk);
        model_step(v, mx, mn, cur, t, clr);
        #1;
        check_all();
    endtask

    task automatic strobes(input int n, input logic [15:0] mx, input logic [15:0] mn,
                           input logic [15:0] cur, input logic [7:0] t);
        for (int k = 0; k < n; k++) cyc(1'b1, mx, mn, cur, t, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        clear_faults = 1'b0;
        #1;
        model_reset();
        check("rst_any", 32'(fault_any), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] rmx, rmn, rcur;
        logic [7:0]  rt;
        int          mag;
        m_latch[0] = 0; m_latch[1] = 0; m_latch[2] = 0; m_latch[3] = 0;
`ifdef BMS_FAULT_LATCH_EN
        m_latch[0] = 1; m_latch[2] = 1; m_latch[3] = 1;
`endif
        rst_n = 1'b0; sample_valid = 1'b0; clear_faults = 1'b0;
        max_cell_mv = NMX; min_cell_mv = NMN; current_ma = NCUR; temp_c = NT;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ov", 32'(ov_fault), 32'd0);
        check("rst_uv", 32'(uv_fault), 32'd0);
        check("rst_oc", 32'(oc_fault), 32'd0);
        check("rst_ot", 32'(ot_fault), 32'd0);
        check("rst_any", 32'(fault_any), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // OV assert on the 4th strobe
        strobes(3, 16'd4200, NMN, NCUR, NT);
        check("ov_pre", 32'(ov_fault), 32'd0);
        strobes(1, 16'd4200, NMN, NCUR, NT);
        check("ov_set", 32'(ov_fault), 32'd1);
        check("ov_any", 32'(fault_any), 32'd1);

        // OV hysteresis band and interrupted release
        strobes(10, 16'd4180, NMN, NCUR, NT);
        check("ov_band", 32'(ov_fault), 32'd1);
        strobes(3, 16'd4150, NMN, NCUR, NT);
        strobes(1, 16'd4180, NMN, NCUR, NT);
        strobes(3, 16'd4150, NMN, NCUR, NT);
        check("ov_rel_pre", 32'(ov_fault), 32'd1);
        strobes(1, 16'd4150, NMN, NCUR, NT);
`ifdef BMS_FAULT_LATCH_EN
        check("ov_latched", 32'(ov_fault), 32'd1);
        cyc(1'b0, NMX, NMN, NCUR, NT, 1'b1);
`endif
        check("ov_rel", 32'(ov_fault), 32'd0);

        // Debounce restart on one non-qualifying sample
        do_reset();
        strobes(3, 16'd4200, NMN, NCUR, NT);
        strobes(1, 16'd4199, NMN, NCUR, NT);
        strobes(3, 16'd4200, NMN, NCUR, NT);
        check("deb_hold", 32'(ov_fault), 32'd0);
        strobes(1, 16'd4200, NMN, NCUR, NT);
        check("deb_set", 32'(ov_fault), 32'd1);

        // OC magnitude, including the saturated -32768 case
        do_reset();
        strobes(4, NMX, NMN, 16'(-20000), NT);
        check("oc_neg", 32'(oc_fault), 32'd1);
        do_reset();
        strobes(4, NMX, NMN, 16'h8000, NT);
        check("oc_sat", 32'(oc_fault), 32'd1);
        strobes(4, NMX, NMN, 16'd19000, NT);
        check("oc_band", 32'(oc_fault), 32'd1);

        // OT signed compare and concurrent UV
        do_reset();
        strobes(4, NMX, NMN, NCUR, 8'(-40));
        check("ot_cold", 32'(ot_fault), 32'd0);
        strobes(4, NMX, 16'd3000, NCUR, 8'd60);
        check("ot_set", 32'(ot_fault), 32'd1);
        check("uv_set", 32'(uv_fault), 32'd1);
        check("ot_any", 32'(fault_any), 32'd1);

        // Reset during the 3rd qualifying strobe discards the partial count
        do_reset();
        strobes(2, 16'd4200, NMN, NCUR, NT);
        @(negedge clk);
        sample_valid = 1'b1;
        max_cell_mv  = 16'd4200;
        rst_n        = 1'b0;
        #1;
        model_reset();
        check("mid_rst_ov", 32'(ov_fault), 32'd0);
        check("mid_rst_any", 32'(fault_any), 32'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        sample_valid = 1'b0;
        strobes(3, 16'd4200, NMN, NCUR, NT);
        check("mid_rst_recount", 32'(ov_fault), 32'd0);
        strobes(1, 16'd4200, NMN, NCUR, NT);
        check("mid_rst_set", 32'(ov_fault), 32'd1);

`ifdef BMS_FAULT_LATCH_EN
        // Latching OT: early clear ignored, clear after release completes
        do_reset();
        strobes(4, NMX, NMN, NCUR, 8'd60);
        strobes(2, NMX, NMN, NCUR, 8'd50);
        cyc(1'b1, NMX, NMN, NCUR, 8'd50, 1'b1);
        strobes(1, NMX, NMN, NCUR, 8'd50);
        check("lat_early", 32'(ot_fault), 32'd1);
        cyc(1'b0, NMX, NMN, NCUR, NT, 1'b0);
        check("lat_hold", 32'(ot_fault), 32'd1);
        cyc(1'b0, NMX, NMN, NCUR, NT, 1'b1);
        check("lat_clear", 32'(ot_fault), 32'd0);
`endif

        // Randomized phase; values held for a few strobes so debounce can complete
        do_reset();
        rmx = NMX; rmn = NMN; rcur = NCUR; rt = NT;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) rmx = 16'($urandom_range(4120, 4230));
            if ($urandom_range(0, 5) == 0) rmn = 16'($urandom_range(2970, 3130));
            if ($urandom_range(0, 5) == 0) begin
                mag  = int'($urandom_range(17500, 20500));
                rcur = ($urandom_range(0, 1) == 1) ? 16'(-mag) : 16'(mag);
                if ($urandom_range(0, 15) == 0) rcur = 16'h8000;
            end
            if ($urandom_range(0, 5) == 0) begin
                rt = 8'($urandom_range(50, 65));
                if ($urandom_range(0, 9) == 0) rt = 8'(-40);
            end
            cyc(($urandom_range(0, 3) != 0), rmx, rmn, rcur, rt, ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
